// File: rtl/vid_stream_capture.sv
// Clocked-video receiver: registers RGB/sync inputs, packs each frame into a
// valid/ready stream packet with sop/eop through a show-ahead FIFO, and measures frame size.
module vid_stream_capture #(
  parameter int DATA_W      = 24,
  parameter int CNT_W       = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic [CNT_W-1:0]  frame_width,
  output logic [CNT_W-1:0]  frame_height,
  output logic              frame_done,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {WAIT_VS, ACTIVE, DROP} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] data_r;
  logic              dv_r, hs_r, vs_r, hs_d, vs_d;
  logic              hs_edge, vs_edge;

  logic              pend_valid, pend_sop, first_seen;
  logic [DATA_W-1:0] pend_data;
  logic [CNT_W-1:0]  pix_cnt, line_cnt, width_cap;

  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W+1:0] head;
  logic              full, empty, pop, push_ok;

  logic              push_req, push_eop, ovf_set, done, capture, start;

  // Syncs reset to their idle level so leaving reset never looks like an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r <= '0;
      dv_r   <= 1'b0;
      hs_r   <= ~SYNC_ACTIVE;
      vs_r   <= ~SYNC_ACTIVE;
      hs_d   <= ~SYNC_ACTIVE;
      vs_d   <= ~SYNC_ACTIVE;
    end else begin
      data_r <= vid_data;
      dv_r   <= vid_datavalid;
      hs_r   <= vid_h_sync;
      vs_r   <= vid_v_sync;
      hs_d   <= hs_r;
      vs_d   <= vs_r;
    end
  end

  assign hs_edge = (hs_r == SYNC_ACTIVE) && (hs_d != SYNC_ACTIVE);
  assign vs_edge = (vs_r == SYNC_ACTIVE) && (vs_d != SYNC_ACTIVE);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && st_ready;
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_VS;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_VS, DROP: if (vs_edge) next_state = enable ? ACTIVE : WAIT_VS;
      ACTIVE: begin
        if (ovf_set)      next_state = DROP;
        else if (vs_edge) next_state = enable ? ACTIVE : WAIT_VS;
      end
      default: next_state = WAIT_VS;
    endcase
  end

  // A v_sync edge closes the current packet and takes priority over a pixel
  always_comb begin
    push_req = 1'b0;
    push_eop = 1'b0;
    capture  = 1'b0;
    if (state == ACTIVE) begin
      if (vs_edge) begin
        push_req = pend_valid;
        push_eop = 1'b1;
      end else if (dv_r) begin
        push_req = pend_valid;
        capture  = 1'b1;
      end
    end
    ovf_set = push_req && full && !pop;
    done    = (state == ACTIVE) && vs_edge && pend_valid && !ovf_set;
    start   = vs_edge && enable && !ovf_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_sop   <= 1'b0;
      pend_data  <= '0;
      first_seen <= 1'b0;
    end else if (vs_edge || ovf_set) begin
      pend_valid <= 1'b0;
      if (start) first_seen <= 1'b0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_data  <= data_r;
      pend_sop   <= !first_seen;
      first_seen <= 1'b1;
    end
  end

  // Width comes from the first line holding pixels; the last line is counted at v_sync
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      width_cap    <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= done;
      if (done) begin
        frame_width  <= (line_cnt == '0) ? pix_cnt : width_cap;
        frame_height <= (pix_cnt != '0 && line_cnt != CNT_MAX) ? line_cnt + CNT_W'(1) : line_cnt;
      end
      if (start) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        width_cap <= '0;
      end else if (state == ACTIVE) begin
        if (hs_edge) begin
          pix_cnt <= '0;
          if (pix_cnt != '0 && line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_W'(1);
          if (pix_cnt != '0 && line_cnt == '0)      width_cap <= pix_cnt;
        end else if (capture && pix_cnt != CNT_MAX) begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (ovf_set)             overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {pend_data, pend_sop, push_eop};
  end

  // Outputs are masked while empty so stale FIFO storage never shows
  assign head     = mem[rd_ptr[AW-1:0]];
  assign st_valid = !empty;
  assign st_data  = empty ? '0 : head[DATA_W+1:2];
  assign st_sop   = !empty && head[1];
  assign st_eop   = !empty && head[0];

endmodule

// File: tb/tb_vid_stream_capture.sv
// Directed self-checking bench for vid_stream_capture: frames, back-pressure,
// overflow recovery, empty frames, enable gating and mid-frame reset.
module tb_vid_stream_capture;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              reset_n, enable, clear_overflow;
  logic [DATA_W-1:0] vid_data;
  logic              vid_datavalid, vid_h_sync, vid_v_sync;
  logic [DATA_W-1:0] st_data;
  logic              st_valid, st_sop, st_eop, frame_done, overflow;
  logic              st_ready = 1'b0;
  logic [CNT_W-1:0]  frame_width, frame_height;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  logic [DATA_W+1:0] beats [$];

  vid_stream_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(16), .SYNC_ACTIVE(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop),
    .frame_width(frame_width), .frame_height(frame_height),
    .frame_done(frame_done), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // 0: always ready, 1: toggle every cycle, 2: stalled
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       st_ready = 1'b1;
      1:       st_ready = ~st_ready;
      default: st_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (st_valid && st_ready) beats.push_back({st_data, st_sop, st_eop});
    if (frame_done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_vsync();
    vid_v_sync = 1'b0;
    step(3);
    vid_v_sync = 1'b1;
    step(3);
  endtask

  task automatic send_line(input int ppl, inout logic [DATA_W-1:0] val);
    vid_h_sync = 1'b0;
    step(2);
    vid_h_sync = 1'b1;
    step(2);
    for (int p = 0; p < ppl; p++) begin
      vid_data      = val;
      vid_datavalid = 1'b1;
      val           = val + 1'b1;
      step();
    end
    vid_datavalid = 1'b0;
    step(2);
  endtask

  // Opens a frame with a v_sync edge and sends its lines; the frame closes on the next v_sync
  task automatic applyStimulus(input int lines, input int ppl, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] v;
    v = base;
    send_vsync();
    for (int l = 0; l < lines; l++) send_line(ppl, v);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [DATA_W-1:0] base,
                             input bit eop_last);
    logic [DATA_W+1:0] exp;
    int m;
    checkOutput({tag, "_count"}, beats.size(), n);
    m = (beats.size() < n) ? beats.size() : n;
    for (int i = 0; i < m; i++) begin
      exp = {base + DATA_W'(i), (i == 0), eop_last && (i == n - 1)};
      checkOutput($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp));
    end
    beats.delete();
  endtask

  initial begin
    int d0;
    reset_n        = 1'b0;
    enable         = 1'b1;
    clear_overflow = 1'b0;
    vid_data       = '0;
    vid_datavalid  = 1'b0;
    vid_h_sync     = 1'b1;
    vid_v_sync     = 1'b1;
    step(3);
    checkOutput("rst_valid", st_valid, 0);
    checkOutput("rst_sop", st_sop, 0);
    checkOutput("rst_eop", st_eop, 0);
    checkOutput("rst_data", st_data, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_width", frame_width, 0);
    checkOutput("rst_height", frame_height, 0);
    reset_n = 1'b1;
    step(2);

    $display("[TB] 2x4 frame, ready high");
    applyStimulus(2, 4, 24'h000001);
    send_vsync();
    step(30);
    check_beats("f1", 8, 24'h000001, 1'b1);
    checkOutput("f1_done", done_cnt, 1);
    checkOutput("f1_width", frame_width, 4);
    checkOutput("f1_height", frame_height, 2);

    $display("[TB] 2x4 frame, ready toggling");
    ready_mode = 1;
    applyStimulus(2, 4, 24'h000001);
    send_vsync();
    step(30);
    check_beats("f2", 8, 24'h000001, 1'b1);
    checkOutput("f2_done", done_cnt, 2);
    checkOutput("f2_ovf", overflow, 0);

    $display("[TB] 1x32 frame, ready low");
    ready_mode = 2;
    step(2);
    applyStimulus(1, 32, 24'h000100);
    send_vsync();
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_valid", st_valid, 1);
    checkOutput("ovf_state", dut.state, 2'd1);
    ready_mode = 0;
    step(30);
    check_beats("ovf", 16, 24'h000100, 1'b0);
    checkOutput("ovf_done", done_cnt, 2);
    checkOutput("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    checkOutput("ovf_clear", overflow, 0);
    applyStimulus(2, 4, 24'h000200);
    send_vsync();
    step(30);
    check_beats("rec", 8, 24'h000200, 1'b1);
    checkOutput("rec_done", done_cnt, 3);
    checkOutput("rec_width", frame_width, 4);

    $display("[TB] 3x5 frame then empty frame");
    applyStimulus(3, 5, 24'h000300);
    send_vsync();
    step(30);
    check_beats("f35", 15, 24'h000300, 1'b1);
    checkOutput("f35_width", frame_width, 5);
    checkOutput("f35_height", frame_height, 3);
    step(5);
    send_vsync();
    step(20);
    check_beats("empty", 0, 24'h0, 1'b0);
    checkOutput("empty_done", done_cnt, 4);
    checkOutput("empty_width", frame_width, 5);
    checkOutput("empty_height", frame_height, 3);

    $display("[TB] enable low before v_sync");
    enable = 1'b0;
    send_vsync();
    applyStimulus(2, 4, 24'h000400);
    send_vsync();
    step(20);
    check_beats("dis", 0, 24'h0, 1'b0);
    checkOutput("dis_done", done_cnt, 4);

    $display("[TB] enable dropped mid-frame");
    enable = 1'b1;
    d0 = done_cnt;
    begin
      logic [DATA_W-1:0] v;
      v = 24'h000500;
      send_vsync();
      send_line(4, v);
      enable = 1'b0;
      send_line(4, v);
    end
    send_vsync();
    applyStimulus(2, 4, 24'h000600);
    send_vsync();
    step(30);
    check_beats("mid", 8, 24'h000500, 1'b1);
    checkOutput("mid_done", done_cnt, d0 + 1);
    checkOutput("mid_state", dut.state, 2'd0);

    $display("[TB] reset after 3 pixels");
    enable     = 1'b1;
    ready_mode = 2;
    step(2);
    begin
      logic [DATA_W-1:0] v;
      v = 24'h000700;
      send_vsync();
      vid_h_sync = 1'b0;
      step(2);
      vid_h_sync = 1'b1;
      step(2);
      for (int p = 0; p < 3; p++) begin
        vid_data      = v;
        vid_datavalid = 1'b1;
        v             = v + 1'b1;
        step();
      end
      vid_datavalid = 1'b0;
      step(3);
    end
    checkOutput("prerst_valid", st_valid, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", st_valid, 0);
    checkOutput("arst_ovf", overflow, 0);
    checkOutput("arst_eop", st_eop, 0);
    step(2);
    reset_n    = 1'b1;
    ready_mode = 0;
    step(2);
    beats.delete();
    d0 = done_cnt;
    applyStimulus(2, 4, 24'h000800);
    send_vsync();
    step(30);
    check_beats("post", 8, 24'h000800, 1'b1);
    checkOutput("post_done", done_cnt, d0 + 1);
    checkOutput("post_width", frame_width, 4);
    checkOutput("post_height", frame_height, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
